led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Multi-channel LED pattern generator driving the board status LEDs from the `clk50` domain. A shared prescaler produces a slow tick. Each channel runs its own runtime-configurable mode: off, on, blink, or burst (N pulses, then a gap). It replaces fixed free-running-counter blinkers with a parametrised block that supervisory logic can reconfigure per channel at run time.

## Interface
- `CHANNELS`, 2: number of independent LED channels (1..16).
- `PRESCALE`, 50000: clk50 cycles per tick (≥1); the default gives a 1 kHz tick.
- `PERIOD_W`, 16: width of the half-period field and the phase counter.
- `GAP_HALVES`, 4: length of the burst gap, in half-periods (≥1).

- `clk50` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: configuration write strobe, one cycle.
- `cfg_ch` in max(1,clog2(CHANNELS)): target channel.
- `cfg_mode` in 2: 0 = OFF, 1 = ON, 2 = BLINK, 3 = BURST.
- `cfg_half` in PERIOD_W: half-period in ticks; 0 is treated as 1.
- `cfg_burst` in 4: pulses per burst; 0 makes BURST output constant low.
- `led` out CHANNELS: registered LED drive, bit i = channel i.
- `tick` out 1: registered prescaler strobe, one cycle wide.

## Operation
- **Prescaler**
  - `pcnt` counts 0..PRESCALE-1 and wraps.
  - `tick` is 1 in the cycle after `pcnt` == PRESCALE-1.
  - With PRESCALE=1, `tick` is constantly 1 after the first edge.
- **Per-channel state:** `mode`, `half`, `burst`, `phase` (PERIOD_W), `level`, `pcount` (4 bits), `in_gap`.
- **Configuration write** (`cfg_we`=1, `cfg_ch` < CHANNELS):
  - Loads `mode`, `half` and `burst` into the target channel.
  - Clears `phase`, `pcount` and `in_gap`; sets `level`=1.
  - A write with `cfg_ch` ≥ CHANNELS is ignored entirely.
- **OFF:** `led`=0. **ON:** `led`=1. Neither mode advances the phase.
- **BLINK**, on each tick:
  - If `phase` == `half`-1: `phase`←0 and `level` toggles.
  - Otherwise `phase`++.
  - `led` follows `level`. The channel shows `half` ticks high, then `half` ticks low, repeating.
- **BURST** uses the same phase mechanism.
  - At the end of a high phase, `pcount`++.
  - If the new `pcount` == `burst`: enter the gap (`in_gap`=1, `level`=0, `pcount`←0). The gap lasts GAP_HALVES half-periods, counted in `pcount`.
  - When the gap ends: `in_gap`=0, `level`=1, and the pulse train restarts.
  - Otherwise the normal low phase follows.
  - Per burst cycle, the output is `burst` high phases separated by `burst`-1 low phases, then GAP_HALVES×`half` ticks low.
- **Precedence:** a write and a tick in the same cycle on the same channel apply the write only; that tick is lost for that channel. Other channels still advance.
- Phase arithmetic is unsigned and wraps at 2^PERIOD_W. It cannot overflow because the phase resets at `half`-1.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - `led`=0, `tick`=0, `pcnt`=0.
  - All channels: `mode`=OFF, `phase`=0, `pcount`=0, `in_gap`=0, `level`=0.
- Reset asserted mid-operation clears everything immediately, with no clock required.
- The first `tick` occurs PRESCALE edges after reset release.
- A write sampled at edge n is visible on `led` after edge n+1 (one-cycle latency).
- `led` transitions occur exactly one cycle after the tick that causes them.
- `tick` high time is 1 cycle; its period is PRESCALE cycles.

## Test plan
All scenarios use PRESCALE=4, CHANNELS=2, PERIOD_W=8, GAP_HALVES=4.

- **Reset:**
  - Stimulus: release `rst_n`, then hold `cfg_we`=0.
  - Required: `led`=00, and `tick` pulses every 4 cycles with the first pulse after edge 4.
  - Stimulus: drop `rst_n` mid-pulse.
  - Required: `led` and `tick` go to 0 asynchronously.
- **BLINK:**
  - Stimulus: ch0 BLINK with `half`=3.
  - Required: `led[0]` high for 12 cycles, low for 12, repeating, with edges 1 cycle after the tick. `led[1]` stays 0.
- **BURST:**
  - Stimulus: ch1 BURST with `half`=1, `burst`=2.
  - Required, per tick: H, L, H, then 4 ticks low, then H, L, H, repeating.
  - Stimulus: `burst`=0.
  - Required: `led[1]` stays 0.
- **ON/OFF:**
  - Stimulus: ch0 ON, then OFF three cycles later.
  - Required: `led[0]` = 1 for exactly 3 cycles, each change 1 cycle after its write.
- **Boundaries:**
  - Stimulus: `half`=0.
  - Required: behaves as `half`=1, i.e. a toggle on every tick.
  - Stimulus: `cfg_ch`=2.
  - Required: no state change on either channel.
  - Stimulus: a write to ch0 coinciding with a tick.
  - Required: ch0 restarts with `level`=1 and `phase`=0; ch1 advances normally.
- **Reconfigure mid-burst:**
  - Stimulus: a BLINK write to a channel during its gap.
  - Required: the gap aborts and `led` goes high the next cycle.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: shared tick prescaler plus per-channel OFF/ON/BLINK/BURST LED sequencers
module led_pattern_gen #(
  parameter int CHANNELS   = 2,
  parameter int PRESCALE   = 50000,
  parameter int PERIOD_W   = 16,
  parameter int GAP_HALVES = 4,
  localparam int CH_W      = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int PCNT_W    = PRESCALE > 1 ? $clog2(PRESCALE) : 1
) (
  input  logic                clk50,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_half,
  input  logic [3:0]          cfg_burst,
  output logic [CHANNELS-1:0] led,
  output logic                tick
);
  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BURST = 2'd3;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic tick_q, tick_d;
  logic [CHANNELS-1:0] led_q, led_d;
  logic [CHANNELS-1:0][1:0] mode_q, mode_d;
  logic [CHANNELS-1:0][PERIOD_W-1:0] half_q, half_d, phase_q, phase_d, h_eff;
  logic [CHANNELS-1:0][3:0] burst_q, burst_d, pcount_q, pcount_d, pc_inc;
  logic [CHANNELS-1:0] level_q, level_d, in_gap_q, in_gap_d, end_ph;
  always_comb begin
    pcnt_d = pcnt_q == PCNT_W'(PRESCALE - 1) ? '0 : pcnt_q + 1'b1;
    tick_d = pcnt_q == PCNT_W'(PRESCALE - 1);
    mode_d = mode_q;
    half_d = half_q;
    burst_d = burst_q;
    phase_d = phase_q;
    level_d = level_q;
    pcount_d = pcount_q;
    in_gap_d = in_gap_q;
    h_eff = '0;
    pc_inc = '0;
    end_ph = '0;
    led_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      h_eff[i] = half_q[i] == '0 ? PERIOD_W'(1) : half_q[i];
      end_ph[i] = phase_q[i] == h_eff[i] - PERIOD_W'(1);
      pc_inc[i] = pcount_q[i] + 4'd1;
      if (cfg_we && cfg_ch == CH_W'(i)) begin
        mode_d[i] = cfg_mode;
        half_d[i] = cfg_half;
        burst_d[i] = cfg_burst;
        phase_d[i] = '0;
        pcount_d[i] = '0;
        in_gap_d[i] = 1'b0;
        level_d[i] = 1'b1;
      end else if (tick_q && mode_q[i][1]) begin
        phase_d[i] = end_ph[i] ? '0 : phase_q[i] + PERIOD_W'(1);
        if (end_ph[i]) begin
          if (mode_q[i] == M_BLINK) begin
            level_d[i] = ~level_q[i];
          end else if (in_gap_q[i]) begin
            // the gap is measured in half-periods, reusing the pulse counter
            in_gap_d[i] = pc_inc[i] != 4'(GAP_HALVES);
            level_d[i] = pc_inc[i] == 4'(GAP_HALVES);
            pcount_d[i] = pc_inc[i] == 4'(GAP_HALVES) ? 4'd0 : pc_inc[i];
          end else if (level_q[i]) begin
            in_gap_d[i] = pc_inc[i] == burst_q[i];
            level_d[i] = 1'b0;
            pcount_d[i] = pc_inc[i] == burst_q[i] ? 4'd0 : pc_inc[i];
          end else begin
            level_d[i] = 1'b1;
          end
        end
      end
      led_d[i] = mode_q[i] == M_ON || (mode_q[i] == M_BLINK && level_q[i]) ||
                 (mode_q[i] == M_BURST && level_q[i] && burst_q[i] != 4'd0);
    end
  end
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
      led_q <= '0;
      mode_q <= {CHANNELS{M_OFF}};
      half_q <= '0;
      burst_q <= '0;
      phase_q <= '0;
      level_q <= '0;
      pcount_q <= '0;
      in_gap_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
      led_q <= led_d;
      mode_q <= mode_d;
      half_q <= half_d;
      burst_q <= burst_d;
      phase_q <= phase_d;
      level_q <= level_d;
      pcount_q <= pcount_d;
      in_gap_q <= in_gap_d;
    end
  end
  assign led = led_q;
  assign tick = tick_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed table, corner sequences and random writes against a tick-count reference model
module tb_led_pattern_gen;
  localparam int P = 4, G = 4;
  typedef struct {
    bit we;
    bit ch;
    bit [1:0] mode;
    bit [7:0] half;
    bit [3:0] burst;
    int cycles;
    bit [1:0] exp;
  } vec_t;
  logic clk50 = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, cfg_ch = 1'b0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_half = '0;
  logic [3:0] cfg_burst = '0;
  logic [1:0] led;
  logic tick;
  logic we3 = 1'b0;
  logic [1:0] ch3 = '0;
  logic [2:0] led3;
  logic tick3;
  int checks = 0, errors = 0, e = 0;
  int m_mode[2], m_half[2], m_burst[2], m_k[2];
  always #5 clk50 = ~clk50;
  led_pattern_gen #(.CHANNELS(2), .PRESCALE(P), .PERIOD_W(8), .GAP_HALVES(G)) dut (
    .clk50(clk50), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_burst(cfg_burst), .led(led), .tick(tick));
  led_pattern_gen #(.CHANNELS(3), .PRESCALE(P), .PERIOD_W(8), .GAP_HALVES(G)) u3 (
    .clk50(clk50), .rst_n(rst_n), .cfg_we(we3), .cfg_ch(ch3), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_burst(cfg_burst), .led(led3), .tick(tick3));
  // a channel's output depends only on its config and the ticks seen since its last write
  function automatic int halves(int c);
    return m_k[c] / (m_half[c] == 0 ? 1 : m_half[c]);
  endfunction
  function automatic bit model_led(int c);
    int n, b, j;
    n = halves(c);
    b = m_burst[c];
    if (m_mode[c] == 0) return 1'b0;
    if (m_mode[c] == 1) return 1'b1;
    if (m_mode[c] == 2) return n % 2 == 0;
    if (b == 0) return 1'b0;
    j = n % (2 * b - 1 + G);
    return j < 2 * b - 1 && j % 2 == 0;
  endfunction
  function automatic bit model_gap(int c);
    int b;
    b = m_burst[c];
    return m_mode[c] == 3 && b > 0 && halves(c) % (2 * b - 1 + G) >= 2 * b - 1;
  endfunction
  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = 0;
      m_half[c] = 0;
      m_burst[c] = 0;
      m_k[c] = 0;
    end
    e = 0;
  endtask
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d want %0d", name, e, act, exp);
    end
  endtask
  task automatic step(input bit we, input int ch, input int mode, input int half, input int burst);
    logic [1:0] exp;
    bit tk;
    cfg_we = we;
    cfg_ch = ch[0];
    cfg_mode = 2'(mode);
    cfg_half = 8'(half);
    cfg_burst = 4'(burst);
    @(posedge clk50);
    #1;
    e++;
    exp = {model_led(1), model_led(0)};
    tk = e > 1 && (e - 1) % P == 0;
    for (int c = 0; c < 2; c++) begin
      if (we && ch == c) begin
        m_mode[c] = mode;
        m_half[c] = half;
        m_burst[c] = burst;
        m_k[c] = 0;
      end else if (tk && m_mode[c] >= 2) begin
        m_k[c]++;
      end
    end
    check("led", int'(led), int'(exp));
    check("tick", int'(tick), int'(e % P == 0));
    cfg_we = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0);
  endtask
  initial begin
    vec_t tbl[9];
    int cnt;
    bit found;
    tbl = '{
      '{1'b0, 1'b0, 2'd0, 8'd0, 4'd0, 4, 2'b00},
      '{1'b1, 1'b0, 2'd2, 8'd3, 4'd0, 2, 2'b01},
      '{1'b0, 1'b0, 2'd0, 8'd0, 4'd0, 11, 2'b01},
      '{1'b0, 1'b0, 2'd0, 8'd0, 4'd0, 1, 2'b00},
      '{1'b1, 1'b1, 2'd3, 8'd1, 4'd2, 2, 2'b10},
      '{1'b0, 1'b0, 2'd0, 8'd0, 4'd0, 2, 2'b00},
      '{1'b0, 1'b0, 2'd0, 8'd0, 4'd0, 4, 2'b10},
      '{1'b0, 1'b0, 2'd0, 8'd0, 4'd0, 4, 2'b01},
      '{1'b0, 1'b0, 2'd0, 8'd0, 4'd0, 16, 2'b10}
    };
    model_reset();
    #12;
    check("reset_led", int'(led), 0);
    check("reset_tick", int'(tick), 0);
    @(posedge clk50);
    #1 rst_n = 1'b1;
    for (int t = 0; t < 9; t++) begin
      step(tbl[t].we, int'(tbl[t].ch), int'(tbl[t].mode), int'(tbl[t].half), int'(tbl[t].burst));
      idle(tbl[t].cycles - 1);
      check($sformatf("table%0d", t), int'(led), int'(tbl[t].exp));
    end
    step(1'b1, 0, 0, 0, 0);
    step(1'b1, 0, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) step(1'b1, 0, 0, 0, 0);
      else step(1'b0, 0, 0, 0, 0);
      cnt += int'(led[0]);
    end
    check("on_off_cycles", cnt, 3);
    step(1'b1, 0, 2, 0, 0);
    idle(16);
    step(1'b1, 1, 2, 2, 0);
    for (int i = 0; i < P && e % P != 0; i++) idle(1);
    step(1'b1, 0, 2, 2, 0);
    idle(1);
    check("write_on_tick", int'(led[0]), 1);
    idle(10);
    we3 = 1'b1;
    ch3 = 2'd3;
    step(1'b0, 0, 1, 0, 0);
    we3 = 1'b0;
    idle(3);
    check("out_of_range", int'(led3), 0);
    we3 = 1'b1;
    ch3 = 2'd2;
    step(1'b0, 0, 1, 0, 0);
    we3 = 1'b0;
    idle(1);
    check("ch2_write", int'(led3), 4);
    step(1'b1, 1, 3, 1, 1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle(1);
      found = model_gap(1);
    end
    check("gap_reached", int'(found), 1);
    step(1'b1, 1, 2, 3, 0);
    idle(1);
    check("gap_abort", int'(led[1]), 1);
    step(1'b1, 1, 3, 1, 0);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      idle(1);
      cnt += int'(led[1]);
    end
    check("burst_zero", cnt, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0)
        step(1'b1, int'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(3)),
             int'($urandom_range(3)));
      else idle(1);
    end
    step(1'b1, 0, 1, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      idle(1);
      found = tick;
    end
    check("tick_before_reset", int'(found), 1);
    check("led_before_reset", int'(led[0]), 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_led", int'(led), 0);
    check("async_tick", int'(tick), 0);
    @(posedge clk50);
    #1 rst_n = 1'b1;
    model_reset();
    step(1'b1, 1, 3, 1, 2);
    idle(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
